// File: rtl/zmod_pkg.sv
// Shared definitions for the ZMOD ADC capture path: FSM state encoding
// and the default sample width.
package zmod_pkg;

  localparam int DATA_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/capture_ram_v1_0.sv
// Simple dual-port capture memory: one synchronous write port and one
// registered read port with a single cycle of latency. Contents are never
// cleared so the structure maps onto block or distributed RAM.
module capture_ram_v1_0
  import zmod_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one sample per enabled clock.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: address sampled every clock, data available one cycle later.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/zmod_adc_capture_v1_0.sv
// Triggered capture buffer for the ZMOD ADC path. A free-running decimator
// produces sample strobes; once armed, a rising level crossing (or a forced
// trigger) starts recording DEPTH decimated samples, which are then streamed
// out through a valid/ready port at most one word every two cycles.
module zmod_adc_capture_v1_0
  import zmod_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] is14_data,
  input  logic        [31:0]       i32_prescaler,
  input  logic signed [DATA_W-1:0] is14_trigger_level,
  input  logic                     i_arm,
  input  logic                     i_force_trigger,
  output logic                     o_armed,
  output logic                     o_done,
  output logic signed [DATA_W-1:0] os14_data,
  output logic        [ADDR_W-1:0] o7_addr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                     state;
  state_t                     next_state;
  logic        [31:0]         presc_cnt;
  logic        [31:0]         presc_top;
  logic                       strobe;
  logic signed [DATA_W-1:0]   prev_data;
  logic                       prev_valid;
  logic                       level_hit;
  logic                       mem_we;
  logic        [ADDR_W-1:0]   mem_wa;
  logic        [ADDR_W-1:0]   waddr;
  logic        [ADDR_W-1:0]   raddr;
  logic        [DATA_W-1:0]   ram_q;
  logic                       ld_pend;
  logic                       ld_wait;
  logic                       accept;

  // Terminal count of the decimator; prescaler values 0 and 1 both strobe every clock.
  always_comb begin
    if (i32_prescaler > 32'd1) begin
      presc_top = i32_prescaler - 32'd1;
    end else begin
      presc_top = 32'd0;
    end
  end

  assign strobe = (presc_cnt == 32'd0);
  assign accept = o_valid && i_ready;

  // Decimation counter, free-running in every state; >= tolerates a live prescaler decrease.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= 32'd0;
    end else if (presc_cnt >= presc_top) begin
      presc_cnt <= 32'd0;
    end else begin
      presc_cnt <= presc_cnt + 32'd1;
    end
  end

  // Signed rising-edge level crossing between the previous and current strobed sample.
  always_comb begin
    if (prev_valid && ($signed(prev_data) < $signed(is14_trigger_level))
        && ($signed(is14_data) >= $signed(is14_trigger_level))) begin
      level_hit = 1'b1;
    end else begin
      level_hit = 1'b0;
    end
  end

  // Next-state logic and RAM write control.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_wa     = waddr;
    case (state)
      IDLE: begin
        if (i_arm) begin
          next_state = ARMED;
        end else begin
          next_state = IDLE;
        end
      end
      ARMED: begin
        if (strobe && (level_hit || i_force_trigger)) begin
          mem_we     = 1'b1;
          mem_wa     = {ADDR_W{1'b0}};
          next_state = CAPTURE;
        end else begin
          next_state = ARMED;
        end
      end
      CAPTURE: begin
        if (strobe) begin
          mem_we = 1'b1;
          if (waddr == LAST_ADDR) begin
            next_state = DONE;
          end else begin
            next_state = CAPTURE;
          end
        end else begin
          next_state = CAPTURE;
        end
      end
      DONE: begin
        if (i_arm) begin
          next_state = ARMED;
        end else if (accept && o_last) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      o_armed <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= next_state;
      o_armed <= (next_state == ARMED);
      o_done  <= (next_state == DONE);
    end
  end

  // Previous-sample register; invalidated on every entry into ARMED so the first strobe cannot level-trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data  <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (strobe) begin
        prev_data <= is14_data;
      end
      if ((state != ARMED) && (next_state == ARMED)) begin
        prev_valid <= 1'b0;
      end else if (strobe) begin
        prev_valid <= 1'b1;
      end
    end
  end

  // Write pointer: follows each RAM write, so the trigger write leaves it at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr <= {ADDR_W{1'b0}};
    end else if (mem_we) begin
      waddr <= mem_wa + ADDR_W'(1);
    end
  end

  capture_ram_v1_0 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_wa),
    .wdata (is14_data),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Readout: raddr runs one word ahead so the RAM output is ready one cycle after each acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr     <= {ADDR_W{1'b0}};
      ld_pend   <= 1'b0;
      ld_wait   <= 1'b0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      os14_data <= '0;
      o7_addr   <= {ADDR_W{1'b0}};
    end else if (next_state != DONE) begin
      raddr   <= {ADDR_W{1'b0}};
      ld_pend <= 1'b0;
      ld_wait <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (state != DONE) begin
      raddr   <= {ADDR_W{1'b0}};
      ld_pend <= 1'b1;
      ld_wait <= 1'b1;
    end else if (accept) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      ld_pend <= 1'b1;
      ld_wait <= 1'b0;
    end else if (ld_pend && ld_wait) begin
      ld_wait <= 1'b0;
    end else if (ld_pend) begin
      o_valid   <= 1'b1;
      os14_data <= ram_q;
      o7_addr   <= raddr;
      o_last    <= (raddr == LAST_ADDR);
      raddr     <= raddr + ADDR_W'(1);
      ld_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zmod_adc_capture_v1_0.sv
// Self-checking bench for zmod_adc_capture_v1_0. Each scenario fills a per-edge
// stimulus table, a behavioural model scans that table to find the trigger and
// the expected record, and the DUT run is compared edge by edge and word by word.
module tb_zmod_adc_capture_v1_0;

  localparam int DEPTH  = 128;
  localparam int DATA_W = 14;
  localparam int NSTIM  = 2048;

  logic                     clk;
  logic                     rst;
  logic signed [DATA_W-1:0] data;
  logic        [31:0]       prescaler;
  logic signed [DATA_W-1:0] level;
  logic                     arm;
  logic                     force_trig;
  logic                     armed;
  logic                     done;
  logic signed [DATA_W-1:0] rd_data;
  logic        [6:0]        rd_addr;
  logic                     valid;
  logic                     ready;
  logic                     last;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DATA_W-1:0] stim [NSTIM];
  logic                     frc  [NSTIM];
  logic signed [DATA_W-1:0] exp_rec [DEPTH];
  int                       exp_t;
  int                       exp_p;

  zmod_adc_capture_v1_0 dut (
    .clk                (clk),
    .rst                (rst),
    .is14_data          (data),
    .i32_prescaler      (prescaler),
    .is14_trigger_level (level),
    .i_arm              (arm),
    .i_force_trigger    (force_trig),
    .o_armed            (armed),
    .o_done             (done),
    .os14_data          (rd_data),
    .o7_addr            (rd_addr),
    .o_valid            (valid),
    .i_ready            (ready),
    .o_last             (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int e = 0; e < NSTIM; e++) begin
      stim[e] = '0;
      frc[e]  = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; ready = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  // Model: after arming at edge 0, strobes occur on edges e>0 with e % P == 0.
  // The first strobe only primes the previous sample; later strobes trigger on a
  // signed rising crossing, any strobe triggers when forced.
  task automatic model_capture(input int p, input logic signed [DATA_W-1:0] lvl, input int nmax);
    logic signed [DATA_W-1:0] prv;
    logic pv;
    exp_p = (p <= 1) ? 1 : p;
    pv = 1'b0; prv = '0; exp_t = -1;
    for (int e = 1; e < nmax && exp_t < 0; e++) begin
      if (e % exp_p == 0) begin
        if ((pv && prv < lvl && stim[e] >= lvl) || frc[e]) exp_t = e;
        else begin prv = stim[e]; pv = 1'b1; end
      end
    end
    if (exp_t >= 0)
      for (int k = 0; k < DEPTH; k++) exp_rec[k] = stim[exp_t + k * exp_p];
  endtask

  // Drive the table with an arm pulse on edge 0; check o_armed every edge and the DONE edge.
  task automatic run_capture(input string name, input int nmax, output int done_edge);
    int exp_done;
    done_edge = -1;
    exp_done = (exp_t < 0) ? -1 : exp_t + (DEPTH - 1) * exp_p;
    for (int e = 0; e < nmax; e++) begin
      data = stim[e]; force_trig = frc[e]; arm = (e == 0);
      step();
      n_checks++;
      if (armed !== ((exp_t < 0) || (e < exp_t))) begin
        n_fail++;
        $display("FAIL %s armed_edge%0d: got %b expected %b", name, e, armed, (exp_t < 0) || (e < exp_t));
      end
      if (done === 1'b1) begin done_edge = e; break; end
    end
    arm = 1'b0; force_trig = 1'b0;
    n_checks++;
    if (done_edge != exp_done) begin
      n_fail++;
      $display("FAIL %s done_edge: got %0d expected %0d", name, done_edge, exp_done);
    end
  endtask

  // Read the record with random ready; abort_at >= 0 pulses arm when that word is presented.
  task automatic read_all(input string name, input int ready_pct, input int abort_at);
    int idx, cyc;
    logic signed [DATA_W-1:0] sd;
    logic [6:0] sa;
    logic sl, held, acc, rdy;
    idx = 0; cyc = 0; held = 1'b0; sd = '0; sa = '0; sl = 1'b0;
    while (idx < DEPTH && cyc < 4000) begin
      if (cyc <= 1) begin
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL %s early_valid cyc%0d: got %b expected 0", name, cyc, valid); end
      end
      if (cyc == 2) begin
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL %s first_valid_latency: got %b expected 1", name, valid); end
      end
      if (held) begin
        n_checks++;
        if (valid !== 1'b1 || rd_data !== sd || rd_addr !== sa || last !== sl) begin
          n_fail++;
          $display("FAIL %s hold_stable: got v=%b d=%0d a=%0d l=%b expected v=1 d=%0d a=%0d l=%b",
                   name, valid, rd_data, rd_addr, last, sd, sa, sl);
        end
      end
      held = 1'b0; acc = 1'b0;
      if (valid === 1'b1 && abort_at == idx) begin
        arm = 1'b1; ready = 1'b0;
        step();
        arm = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || armed !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s abort: got v=%b armed=%b done=%b expected v=0 armed=1 done=0", name, valid, armed, done);
        end
        return;
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      ready = rdy;
      if (valid === 1'b1) begin
        if (rdy) begin
          n_checks++;
          if (rd_addr !== 7'(idx) || rd_data !== exp_rec[idx] || last !== (idx == DEPTH - 1)) begin
            n_fail++;
            $display("FAIL %s word%0d: got a=%0d d=%0d l=%b expected a=%0d d=%0d l=%b",
                     name, idx, rd_addr, rd_data, last, idx, exp_rec[idx], idx == DEPTH - 1);
          end
          idx++; acc = 1'b1;
        end else begin
          held = 1'b1; sd = rd_data; sa = rd_addr; sl = last;
        end
      end
      step(); cyc++;
      if (acc && idx < DEPTH) begin
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL %s valid_gap: got %b expected 0", name, valid); end
      end
    end
    ready = 1'b0;
    n_checks++;
    if (idx < DEPTH) begin
      n_fail++;
      $display("FAIL %s readout_timeout: got %0d words expected %0d", name, idx, DEPTH);
    end else if (done !== 1'b0 || armed !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: got done=%b armed=%b v=%b expected 0 0 0", name, done, armed, valid);
    end
  endtask

  task automatic test_reset();
    do_reset(4);
    n_checks++;
    if ({armed, done, valid, last, rd_data, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got armed=%b done=%b v=%b l=%b d=%0d a=%0d expected all 0",
               armed, done, valid, last, rd_data, rd_addr);
    end
  endtask

  task automatic test_ramp_trigger();
    int de;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = DATA_W'(e - 50);
    prescaler = 32'd1; level = 14'sd100;
    do_reset(4);
    model_capture(1, level, 1000);
    n_checks++;
    if (exp_t < 0 || exp_rec[0] !== 14'sd100) begin
      n_fail++; $display("FAIL ramp_model_trigger: got t=%0d expected sample 100", exp_t);
    end
    run_capture("ramp", 1000, de);
    if (de >= 0) read_all("ramp", 100, -1);
  endtask

  task automatic test_falling_no_trigger();
    int de;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = DATA_W'(100 - e);
    frc[250] = 1'b1;
    prescaler = 32'd1; level = 14'sd0;
    do_reset(4);
    model_capture(1, level, 1000);
    run_capture("falling", 1000, de);
    if (de >= 0) read_all("falling", 100, -1);
  endtask

  task automatic test_decimation();
    int de;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = DATA_W'(e);
    for (int e = 17; e < 24; e++) frc[e] = 1'b1;
    prescaler = 32'd4; level = 14'sd8191;
    do_reset(4);
    model_capture(4, level, 1500);
    run_capture("decim", 1500, de);
    if (de >= 0) read_all("decim", 30, -1);
  endtask

  task automatic test_backpressure();
    int de, p;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = DATA_W'(int'($urandom_range(0, 600)) - 300);
    frc[300] = 1'b1;
    p = $urandom_range(0, 3);
    prescaler = 32'(p); level = DATA_W'(int'($urandom_range(0, 200)) - 100);
    do_reset(4);
    model_capture(p, level, 1500);
    run_capture("backpressure", 1500, de);
    if (de >= 0) read_all("backpressure", 30, -1);
  endtask

  task automatic test_abort_and_reset();
    int de;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = DATA_W'(int'($urandom_range(0, 4000)) - 2000);
    frc[5] = 1'b1;
    prescaler = 32'd1; level = 14'sd8191;
    do_reset(4);
    model_capture(1, level, 600);
    run_capture("abort", 600, de);
    if (de >= 0) read_all("abort", 100, 10);
    // Force a capture from the re-armed state, then reset in the middle of it.
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (5) step();
    n_checks++;
    if (armed !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midcap_state: got armed=%b done=%b expected 0 0", armed, done);
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if ({armed, done, valid, last, rd_data, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL midcap_reset: got armed=%b done=%b v=%b l=%b d=%0d a=%0d expected all 0",
               armed, done, valid, last, rd_data, rd_addr);
    end
    frc[5] = 1'b0; frc[40] = 1'b1;
    model_capture(1, level, 600);
    run_capture("rearm", 600, de);
    if (de >= 0) read_all("rearm", 60, -1);
  endtask

  task automatic test_signed_boundary();
    int de;
    clear_stim();
    for (int e = 0; e < NSTIM; e++) stim[e] = (e < 50) ? -14'sd8192 : -14'sd8191;
    prescaler = 32'd1; level = -14'sd8192;
    do_reset(4);
    model_capture(1, level, 100);
    run_capture("signed_nohit", 100, de);
    level = -14'sd8191;
    do_reset(4);
    model_capture(1, level, 400);
    n_checks++;
    if (exp_t != 50) begin n_fail++; $display("FAIL signed_model_edge: got %0d expected 50", exp_t); end
    run_capture("signed_hit", 400, de);
    if (de >= 0) read_all("signed_hit", 100, -1);
  endtask

  initial begin
    rst = 1'b1; data = '0; prescaler = 32'd1; level = '0;
    arm = 1'b0; force_trig = 1'b0; ready = 1'b0;
    test_reset();
    test_ramp_trigger();
    test_falling_no_trigger();
    test_decimation();
    test_backpressure();
    test_abort_and_reset();
    test_signed_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zmod_adc_capture_v1_0.md
# zmod_adc_capture_v1_0

Triggered capture buffer for the ZMOD ADC path: the counterpart of the DAC waveform playback memory. Records decimated channel samples from the ZMOD ADC driver into a DEPTH-word RAM, starting at a level-crossing or forced trigger. Exposes the stored record through a valid/ready read port for a logic analyser, UART bridge or processor. Sits in the top module between `zmod_adc_driver_v1_0` outputs and any readout consumer, all in the `clk100mhz` domain.

## Interface
- DEPTH, 128, capture record length in samples; must be a power of two.
- ADDR_W, 7, equals log2(DEPTH).
- DATA_W, 14, sample width; signed two's complement.

- clk  in  1  system clock (clk100mhz domain).
- rst  in  1  synchronous, active-high reset.
- is14_data  in  DATA_W  signed ADC sample, new value possible every clk.
- i32_prescaler  in  32  decimation factor. 0 and 1 both mean take every clk.
- is14_trigger_level  in  DATA_W  signed rising-edge trigger threshold.
- i_arm  in  1  one-cycle pulse; arm the capture.
- i_force_trigger  in  1  trigger immediately when armed, regardless of level.
- o_armed  out  1  high in ARMED.
- o_done  out  1  high in DONE (record complete, readout available).
- os14_data  out  DATA_W  readout sample.
- o7_addr  out  ADDR_W  sample index of os14_data (0 = trigger sample).
- o_valid  out  1  readout word valid.
- i_ready  in  1  consumer accepts word when o_valid && i_ready.
- o_last  out  1  high with o_valid when o7_addr == DEPTH-1.

## Operation
- **Decimation strobe:** counter runs 0..max(i32_prescaler,1)-1. The strobe fires when the counter is 0. The counter free-runs in all states and resets to 0 on rst.
- **Previous-sample register:** updated on every strobe. Marked invalid on entry to ARMED, valid after the first strobe.
- **State machine: IDLE, ARMED, CAPTURE, DONE.**
- **IDLE:**
  - i_arm -> ARMED.
  - Other inputs are ignored.
- **ARMED:** a strobe meeting either condition below writes is14_data to mem[0], sets the write address to 1, and goes to CAPTURE.
  - Level trigger: prev valid && prev < level && current >= level, using signed compare.
  - i_force_trigger high on that strobe.
  - i_arm in ARMED has no effect.
- **CAPTURE:**
  - Each strobe writes mem[waddr] and increments waddr.
  - The strobe writing DEPTH-1 moves to DONE on the same edge.
  - i_arm and i_force_trigger are ignored.
- **DONE:**
  - Read pointer starts at 0.
  - A word is presented with o_valid=1 and held stable until accepted.
  - After acceptance, o_valid drops for one cycle while the next RAM read completes.
  - Acceptance with o_last -> IDLE, o_done falls.
  - i_arm in DONE aborts readout and goes to ARMED. o_valid drops on the next edge.
- **Reset:**
  - Mid-operation reset -> IDLE.
  - All outputs go to 0: o_armed, o_done, o_valid, o_last, os14_data, o7_addr.
  - Counters and pointers clear. RAM contents are not cleared.
- **Threshold and prescaler:** sampled live, so changes take effect on the next strobe.

## Timing
- Trigger strobe at edge t: mem[0] is written at t, and o_armed=0 from t+1.
- With prescaler P, the capture spans DEPTH strobes. DONE is entered at the edge of the (DEPTH-1)th strobe after the trigger, so o_done=1 from that edge.
- First o_valid: 2 cycles after entering DONE (1 cycle RAM read, 1 cycle output register).
- Readout throughput: at most one word per 2 cycles.
- Backpressure: os14_data, o7_addr and o_last must not change while o_valid && !i_ready.
- Trigger on the first strobe after arm is impossible (prev invalid), unless i_force_trigger is high.

## Structure
- Shared package/header `zmod_pkg`:
  - state encodings (IDLE=0, ARMED=1, CAPTURE=2, DONE=3);
  - DATA_W default.
- Sub-module `capture_ram_v1_0`:
  - simple dual-port RAM, DEPTH x DATA_W;
  - synchronous write, registered synchronous read with 1-cycle latency;
  - inferable as BRAM/LUTRAM.
- The FSM, decimator, trigger compare and readout handshake stay in the top of this block.

## Test plan
- **Rising-ramp trigger:** rst 4 cycles, prescaler=1, level=100, ramp input -50..+200 step 1, pulse i_arm.
  - Trigger on sample 100.
  - o_done after 128 strobes.
  - Readout with i_ready=1 gives addr 0..127, data 100..227, o_last only at addr 127, then IDLE.
- **No false trigger on falling edge:** falling ramp through level=0 while armed.
  - o_armed stays 1 and no capture occurs.
  - i_force_trigger then forces a capture starting at the current sample.
- **Decimation:** prescaler=4, counter input (+1 per clk), forced trigger.
  - Stored words differ by exactly 4.
  - o_done appears 4*127 cycles after the trigger edge.
- **Backpressure:** random i_ready with ~30% high.
  - All 128 words arrive in order, with no duplicates or drops.
  - Outputs stay stable while o_valid && !i_ready.
- **Abort and reset:**
  - i_arm at readout word 10 -> o_valid=0 next cycle, o_armed=1.
  - rst during CAPTURE -> all outputs 0 next cycle; a new arm works normally.
- **Signed boundaries:** level=-8192; input steps from -8192 to -8191.
  - No trigger (prev not < level).
  - With level=-8191, the step triggers.
